fb_scanout: RTL and testbench
=============================

FB_SCANOUT -- requirements
Module: fb_scanout

Interface
REQ-001 SHALL have parameters: H_ACTIVE 640, H_FP 16, H_SYNC 96, H_BP 48, V_ACTIVE 480, V_FP 10, V_SYNC 2, V_BP 33, FB_COLS 40, SCALE_SHIFT 4.
REQ-002 clk  in  1  pixel clock; one clock domain.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 fb_base  in  16  framebuffer start address, sampled once per frame.
REQ-005 rd_addr  out  16  read address to the framebuffer RAM read port.
REQ-006 rd_data  in  24  RAM read data, valid 1 cycle after rd_addr; R=[23:16], G=[15:8], B=[7:0].
REQ-007 r, g, b  out  8 each  registered pixel colour.
REQ-008 hsync, vsync  out  1 each  registered, active-low sync.
REQ-009 de  out  1  registered data-enable, high for active pixels.
REQ-010 frame_start  out  1  one-cycle pulse with output pixel (0,0).

Function
REQ-011 h_cnt SHALL count 0..799 and wrap to 0; v_cnt SHALL increment when h_cnt wraps, count 0..524 and wrap to 0.
REQ-012 A pixel is active when h_cnt<640 and v_cnt<480.
REQ-013 Sync SHALL be active (low) when h_cnt is 656..751 (hsync) and when v_cnt is 490..491 (vsync).
REQ-014 Active pixels: rd_addr = base_q + row_off + (h_cnt>>4), mod 2^16, combinational from counter registers. Blanking: rd_addr = 0.
REQ-015 No multiplier: row_off SHALL be 0 on frame start and gain FB_COLS at h_cnt=799 when v_cnt<480 and v_cnt[3:0]=15.
REQ-016 At h_cnt=799, v_cnt=524: base_q <= fb_base and row_off <= 0. fb_base changes mid-frame SHALL NOT affect the current frame.
REQ-017 Pipeline: counters -> RAM (1 cycle) -> output register. r/g/b/de/hsync/vsync/frame_start SHALL lag counter position by exactly 2 cycles, all aligned.
REQ-018 Active outputs: r/g/b = rd_data fields. Otherwise r/g/b = 0, de = 0, regardless of rd_data.
REQ-019 frame_start SHALL be 1 only for the output cycle of counter position (0,0): exactly one pulse per 420000 cycles.
REQ-020 Frame geometry SHALL be 40x30 cells of 16x16 pixels, addresses base_q+0 .. base_q+1199.

Reset
REQ-021 While rst=1: h_cnt=0, v_cnt=0, row_off=0, base_q=0, rd_addr=0, r/g/b=0, de=0, hsync=1, vsync=1, frame_start=0.
REQ-022 Reset mid-frame SHALL abort the frame immediately; no partial-line or stale pipeline data SHALL reach outputs after release.
REQ-023 First cycle after release SHALL be counter (0,0) using base_q=0. frame_start SHALL pulse 2 cycles later.

Structure
REQ-024 Timing constants, FB_COLS, SCALE_SHIFT and the RGB field positions SHALL live in shared package vga_pkg.
REQ-025 Counters and raw sync/active generation SHALL be sub-module vga_timing. fb_scanout adds address generation and the pipeline.
REQ-026 Target size: 120-400 lines of RTL. No RAM inside; the block connects to one port of the team's dual-port framebuffer RAM.

Verification
REQ-027 Reset, then run 2 frames -> hsync low 96 cycles every 800, vsync low for 2 lines (1600 cycles) every 525 lines, frame_start period 420000.
REQ-028 RAM model with 1-cycle latency, data = {8'hA5, addr} -> output pixels (0..15,0) show 0xA50000. Pixel (16,0) shows 0xA50001. Pixel (0,16) shows 0xA50028. Pixel (639,479) shows 0xA504AF. de high for exactly 307200 cycles per frame.
REQ-029 fb_base 0 -> 1200 at line 100 -> remainder of frame reads from base 0. Next frame pixel (0,0) reads addr 1200. Last pixel reads 2399.
REQ-030 rd_data held at 24'hFFFFFF -> r/g/b = 0 on every cycle with de=0, including h_cnt 640..799 and lines 480..524.
REQ-031 rst pulsed 3 cycles at counter (300,200) -> during reset outputs match REQ-021. After release, rd_addr=base 0 and de rises 2 cycles later with frame_start=1.
REQ-032 fb_base=16'hFFF0 -> addresses wrap mod 2^16. Pixel (256,0) reads addr 0x0000.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared video timing constants, framebuffer geometry and RGB field layout
// for the scanout path.
package vga_pkg;
    localparam int unsigned H_ACTIVE    = 640;
    localparam int unsigned H_FP        = 16;
    localparam int unsigned H_SYNC      = 96;
    localparam int unsigned H_BP        = 48;
    localparam int unsigned V_ACTIVE    = 480;
    localparam int unsigned V_FP        = 10;
    localparam int unsigned V_SYNC      = 2;
    localparam int unsigned V_BP        = 33;
    localparam int unsigned FB_COLS     = 40;
    localparam int unsigned SCALE_SHIFT = 4;

    localparam int unsigned CNT_W  = 10;
    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 24;
    localparam int unsigned CH_W   = 8;
    localparam int unsigned R_LSB  = 16;
    localparam int unsigned G_LSB  = 8;
    localparam int unsigned B_LSB  = 0;

    typedef struct packed {
        logic active;
        logic hsync_n;
        logic vsync_n;
        logic frame_start;
    } vid_ctl_t;

    localparam vid_ctl_t CTL_IDLE = '{active: 1'b0, hsync_n: 1'b1, vsync_n: 1'b1, frame_start: 1'b0};
endpackage

// File: rtl/fb_scanout_if.sv
// Read port towards one side of the dual-port framebuffer RAM.
interface fb_scanout_if;
    import vga_pkg::*;

    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;

    modport master (output rd_addr, input rd_data);
    modport slave  (input rd_addr, output rd_data);
endinterface

// File: rtl/fb_scanout_timing.sv
// Raster counters plus unregistered active/sync/frame-start flags for the
// current counter position.
module vga_timing
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE = vga_pkg::H_ACTIVE,
    parameter int unsigned H_FP     = vga_pkg::H_FP,
    parameter int unsigned H_SYNC   = vga_pkg::H_SYNC,
    parameter int unsigned H_BP     = vga_pkg::H_BP,
    parameter int unsigned V_ACTIVE = vga_pkg::V_ACTIVE,
    parameter int unsigned V_FP     = vga_pkg::V_FP,
    parameter int unsigned V_SYNC   = vga_pkg::V_SYNC,
    parameter int unsigned V_BP     = vga_pkg::V_BP
) (
    input  logic             clk,
    input  logic             rst,
    output logic [CNT_W-1:0] h_cnt,
    output logic [CNT_W-1:0] v_cnt,
    output vid_ctl_t         ctl,
    output logic             line_end,
    output logic             frame_end
);
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
    logic [CNT_W-1:0] v_cnt_q, v_cnt_d;

    always_comb begin
        line_end  = (h_cnt_q == CNT_W'(H_TOTAL - 1));
        frame_end = line_end && (v_cnt_q == CNT_W'(V_TOTAL - 1));
        h_cnt_d   = line_end ? '0 : h_cnt_q + 1'b1;
        v_cnt_d   = v_cnt_q;
        if (line_end) begin
            v_cnt_d = frame_end ? '0 : v_cnt_q + 1'b1;
        end

        ctl             = CTL_IDLE;
        ctl.active      = (h_cnt_q < CNT_W'(H_ACTIVE)) && (v_cnt_q < CNT_W'(V_ACTIVE));
        ctl.hsync_n     = !((h_cnt_q >= CNT_W'(H_ACTIVE + H_FP)) &&
                            (h_cnt_q <  CNT_W'(H_ACTIVE + H_FP + H_SYNC)));
        ctl.vsync_n     = !((v_cnt_q >= CNT_W'(V_ACTIVE + V_FP)) &&
                            (v_cnt_q <  CNT_W'(V_ACTIVE + V_FP + V_SYNC)));
        ctl.frame_start = (h_cnt_q == '0) && (v_cnt_q == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    assign h_cnt = h_cnt_q;
    assign v_cnt = v_cnt_q;
endmodule

// File: rtl/fb_scanout.sv
// Framebuffer scanout: cell address generation from the raster counters and a
// two-stage pipeline aligning RAM read data with registered sync/enable.
module fb_scanout
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE    = vga_pkg::H_ACTIVE,
    parameter int unsigned H_FP        = vga_pkg::H_FP,
    parameter int unsigned H_SYNC      = vga_pkg::H_SYNC,
    parameter int unsigned H_BP        = vga_pkg::H_BP,
    parameter int unsigned V_ACTIVE    = vga_pkg::V_ACTIVE,
    parameter int unsigned V_FP        = vga_pkg::V_FP,
    parameter int unsigned V_SYNC      = vga_pkg::V_SYNC,
    parameter int unsigned V_BP        = vga_pkg::V_BP,
    parameter int unsigned FB_COLS     = vga_pkg::FB_COLS,
    parameter int unsigned SCALE_SHIFT = vga_pkg::SCALE_SHIFT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] fb_base,
    fb_scanout_if.master      ram,
    output logic [CH_W-1:0]   r,
    output logic [CH_W-1:0]   g,
    output logic [CH_W-1:0]   b,
    output logic              hsync,
    output logic              vsync,
    output logic              de,
    output logic              frame_start
);
    logic [CNT_W-1:0]  h_cnt, v_cnt;
    vid_ctl_t          ctl;
    logic              line_end, frame_end;

    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] row_off_q, row_off_d;
    logic [ADDR_W-1:0] rd_addr_c;
    vid_ctl_t          ctl1_q, ctl1_d;
    logic [CH_W-1:0]   r_q, r_d, g_q, g_d, b_q, b_d;
    logic              de_q, de_d, hsync_q, hsync_d, vsync_q, vsync_d, fs_q, fs_d;

    vga_timing #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .clk       (clk),
        .rst       (rst),
        .h_cnt     (h_cnt),
        .v_cnt     (v_cnt),
        .ctl       (ctl),
        .line_end  (line_end),
        .frame_end (frame_end)
    );

    always_comb begin
        base_d    = base_q;
        row_off_d = row_off_q;
        // Row offset advances after the last scan line of each cell row, so no multiply is needed.
        if (frame_end) begin
            base_d    = fb_base;
            row_off_d = '0;
        end else if (line_end && (v_cnt < CNT_W'(V_ACTIVE)) && (&v_cnt[SCALE_SHIFT-1:0])) begin
            row_off_d = row_off_q + ADDR_W'(FB_COLS);
        end

        // Held at zero during reset so the RAM never sees a pre-reset position.
        rd_addr_c = '0;
        if (ctl.active && !rst) begin
            rd_addr_c = base_q + row_off_q + ADDR_W'(h_cnt >> SCALE_SHIFT);
        end

        ctl1_d  = ctl;
        r_d     = '0;
        g_d     = '0;
        b_d     = '0;
        if (ctl1_q.active) begin
            r_d = ram.rd_data[R_LSB +: CH_W];
            g_d = ram.rd_data[G_LSB +: CH_W];
            b_d = ram.rd_data[B_LSB +: CH_W];
        end
        de_d    = ctl1_q.active;
        hsync_d = ctl1_q.hsync_n;
        vsync_d = ctl1_q.vsync_n;
        fs_d    = ctl1_q.frame_start;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            base_q    <= '0;
            row_off_q <= '0;
            ctl1_q    <= CTL_IDLE;
            r_q       <= '0;
            g_q       <= '0;
            b_q       <= '0;
            de_q      <= 1'b0;
            hsync_q   <= 1'b1;
            vsync_q   <= 1'b1;
            fs_q      <= 1'b0;
        end else begin
            base_q    <= base_d;
            row_off_q <= row_off_d;
            ctl1_q    <= ctl1_d;
            r_q       <= r_d;
            g_q       <= g_d;
            b_q       <= b_d;
            de_q      <= de_d;
            hsync_q   <= hsync_d;
            vsync_q   <= vsync_d;
            fs_q      <= fs_d;
        end
    end

    assign ram.rd_addr = rd_addr_c;
    assign r           = r_q;
    assign g           = g_q;
    assign b           = b_q;
    assign de          = de_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign frame_start = fs_q;
endmodule

// File: tb/tb_fb_scanout.sv
// Directed bench for fb_scanout on a reduced raster (80x55 total, 4x3 cells)
// so several frames fit in a short run; RAM returns {A5, addr} one cycle late.
module tb_fb_scanout;
    localparam int unsigned HA = 64, HF = 4, HS = 8, HB = 4;
    localparam int unsigned VA = 48, VF = 2, VS = 2, VB = 3;
    localparam int unsigned COLS  = 4;
    localparam int unsigned HT    = HA + HF + HS + HB;
    localparam int unsigned VT    = VA + VF + VS + VB;
    localparam int unsigned FRAME = HT * VT;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] fb_base;
    logic [7:0]  r, g, b;
    logic        hsync, vsync, de, frame_start;
    logic        ram_ff;

    int unsigned tests = 0, fails = 0;
    int unsigned cyc = 0;
    int unsigned de_cnt, hs_lo, vs_lo, fs_cnt, blank_bad;
    int unsigned fs_last = 0, fs_period = 0;

    fb_scanout_if ram ();

    fb_scanout #(
        .H_ACTIVE    (HA),
        .H_FP        (HF),
        .H_SYNC      (HS),
        .H_BP        (HB),
        .V_ACTIVE    (VA),
        .V_FP        (VF),
        .V_SYNC      (VS),
        .V_BP        (VB),
        .FB_COLS     (COLS),
        .SCALE_SHIFT (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .fb_base     (fb_base),
        .ram         (ram),
        .r           (r),
        .g           (g),
        .b           (b),
        .hsync       (hsync),
        .vsync       (vsync),
        .de          (de),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    always @(posedge clk) ram.rd_data <= ram_ff ? 24'hFFFFFF : {8'hA5, ram.rd_addr};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (de) de_cnt++;
        if (!hsync) hs_lo++;
        if (!vsync) vs_lo++;
        if (!de && ({r, g, b} != 24'h0)) blank_bad++;
        if (frame_start) begin
            fs_cnt++;
            fs_period = cyc - fs_last;
            fs_last   = cyc;
        end
    endtask

    task automatic goto(input int unsigned target);
        while (cyc < target) tick();
    endtask

    task automatic zero_stats();
        de_cnt = 0; hs_lo = 0; vs_lo = 0; fs_cnt = 0; blank_bad = 0;
    endtask

    // Sample index at which output pixel (x,y) of frame f is visible.
    function automatic int unsigned pix(input int unsigned f, input int unsigned x, input int unsigned y);
        return f * FRAME + y * HT + x + 2;
    endfunction

    function automatic logic [31:0] rgb();
        return {8'h00, r, g, b};
    endfunction

    initial begin
        zero_stats();
        ram_ff  = 1'b0;
        fb_base = 16'h0000;
        rst     = 1'b1;
        repeat (3) tick();
        check("rst_addr",  32'(ram.rd_addr), 32'h0);
        check("rst_rgb",   rgb(), 32'h0);
        check("rst_de",    32'(de), 32'h0);
        check("rst_hsync", 32'(hsync), 32'h1);
        check("rst_vsync", 32'(vsync), 32'h1);
        check("rst_fs",    32'(frame_start), 32'h0);

        rst = 1'b0;
        cyc = 0;
        check("rel_addr", 32'(ram.rd_addr), 32'h0);
        tick();
        check("c1_fs", 32'(frame_start), 32'h0);
        check("c1_de", 32'(de), 32'h0);
        zero_stats();
        tick();
        check("p00_fs",  32'(frame_start), 32'h1);
        check("p00_de",  32'(de), 32'h1);
        check("p00_rgb", rgb(), 32'h00A50000);

        goto(pix(0, 15, 0));  check("p15_0",  rgb(), 32'h00A50000);
        goto(pix(0, 16, 0));  check("p16_0",  rgb(), 32'h00A50001);
        goto(pix(0, 64, 0));  check("p64_de", 32'(de), 32'h0);
        check("p64_rgb", rgb(), 32'h0);
        goto(pix(0, 67, 0));  check("hs67", 32'(hsync), 32'h1);
        goto(pix(0, 68, 0));  check("hs68", 32'(hsync), 32'h0);
        goto(pix(0, 75, 0));  check("hs75", 32'(hsync), 32'h0);
        goto(pix(0, 76, 0));  check("hs76", 32'(hsync), 32'h1);

        goto(pix(0, 0, 10));
        fb_base = 16'd12;
        goto(pix(0, 0, 16));  check("p0_16",  rgb(), 32'h00A50004);
        goto(pix(0, 63, 47)); check("plast0", rgb(), 32'h00A5000B);
        check("plast0_de", 32'(de), 32'h1);
        goto(pix(0, 79, 49)); check("vs49", 32'(vsync), 32'h1);
        goto(pix(0, 0, 50));  check("vs50", 32'(vsync), 32'h0);
        goto(pix(0, 79, 51)); check("vs51", 32'(vsync), 32'h0);
        goto(pix(0, 0, 52));  check("vs52", 32'(vsync), 32'h1);

        goto(pix(1, 0, 0) - 1);
        check("f0_de_cnt", de_cnt, 32'd3072);
        check("f0_hs_lo",  hs_lo,  32'd440);
        check("f0_vs_lo",  vs_lo,  32'd160);
        check("f0_fs_cnt", fs_cnt, 32'd1);
        zero_stats();

        goto(pix(1, 0, 0));
        check("f1_p00",    rgb(), 32'h00A5000C);
        check("f1_fs",     32'(frame_start), 32'h1);
        check("fs_period", fs_period, FRAME);
        goto(pix(1, 63, 47)); check("f1_plast", rgb(), 32'h00A50017);
        ram_ff = 1'b1;
        goto(pix(2, 0, 0) - 1);
        check("f1_de_cnt", de_cnt, 32'd3072);
        check("f1_hs_lo",  hs_lo,  32'd440);
        check("f1_fs_cnt", fs_cnt, 32'd1);
        check("f1_blank",  blank_bad, 32'd0);
        zero_stats();

        goto(pix(2, 5, 3));   check("ff_active", rgb(), 32'h00FFFFFF);
        goto(pix(3, 0, 0) - 1);
        check("ff_blank",  blank_bad, 32'd0);
        check("ff_de_cnt", de_cnt, 32'd3072);
        ram_ff = 1'b0;

        // Counter position (30,20) of frame 3: row 1, column 1, base 12.
        goto(3 * FRAME + 20 * HT + 30);
        check("mid_addr", 32'(ram.rd_addr), 32'd17);
        rst = 1'b1;
        tick();
        check("mr_rgb",   rgb(), 32'h0);
        check("mr_de",    32'(de), 32'h0);
        check("mr_hsync", 32'(hsync), 32'h1);
        check("mr_vsync", 32'(vsync), 32'h1);
        check("mr_fs",    32'(frame_start), 32'h0);
        check("mr_addr",  32'(ram.rd_addr), 32'h0);
        tick();
        tick();
        rst = 1'b0;
        cyc = 0;
        check("mr_rel_addr", 32'(ram.rd_addr), 32'h0);
        tick();
        check("mr_c1_de", 32'(de), 32'h0);
        check("mr_c1_fs", 32'(frame_start), 32'h0);
        tick();
        check("mr_c2_de",  32'(de), 32'h1);
        check("mr_c2_fs",  32'(frame_start), 32'h1);
        check("mr_c2_rgb", rgb(), 32'h00A50000);

        fb_base = 16'hFFF8;
        goto(pix(1, 0, 0));   check("wr_p00", rgb(), 32'h00A5FFF8);
        goto(FRAME + 32 * HT); check("wr_addr", 32'(ram.rd_addr), 32'h0);
        goto(pix(1, 0, 32));  check("wr_p0_32", rgb(), 32'h00A50000);
        goto(pix(1, 63, 47)); check("wr_plast", rgb(), 32'h00A50003);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
